cache_fill_fsm: RTL and testbench

Miss-handling controller for the instruction and data caches. It sits between the cache tag/data arrays and the shared multi-cycle main memory, directly upstream of the pipeline's fetch and memory stages. On a miss it fetches the full 8-word block, streams each returned word into the data array, then writes the tag. While it does this, the pipeline stalls on `fsm_busy`.

---
 rtl/cache_fill_fsm_pkg.sv | 14 +
 rtl/cache_fill_fsm_if.sv | 32 +++
 rtl/cache_fill_cnt.sv | 24 ++
 rtl/cache_fill_fsm.sv | 89 ++++++++
 tb/tb_cache_fill_fsm.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and sizing for the cache miss-fill controller.
// BLOCK_WORDS here is the default block size used by the I- and D-cache instances.
package wisc_cache_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int OFFSET_BITS = $clog2(2 * BLOCK_WORDS);
  localparam int WIDX_W      = $clog2(BLOCK_WORDS);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Cache-side and memory-side signals of one fill controller.
// The master modport is the FSM; the slave modport is the cache/memory environment.
interface cache_fill_if #(
  parameter int AWIDTH      = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int WIDX_W = $clog2(BLOCK_WORDS);

  logic              miss_detected;
  logic [AWIDTH-1:0] miss_address;
  logic              mem_grant;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_enable;
  logic [AWIDTH-1:0] memory_address;
  logic              write_data_array;
  logic [WIDX_W-1:0] word_offset;
  logic              write_tag_array;
  logic [AWIDTH-1:0] block_base;

  modport master (
    input  miss_detected, miss_address, mem_grant, memory_data_valid,
    output fsm_busy, mem_enable, memory_address, write_data_array,
           word_offset, write_tag_array, block_base
  );

  modport slave (
    output miss_detected, miss_address, mem_grant, memory_data_valid,
    input  fsm_busy, mem_enable, memory_address, write_data_array,
           word_offset, write_tag_array, block_base
  );
endinterface

// File: rtl/cache_fill_cnt.sv
// Up-counter with synchronous clear (priority over enable) and async active-low reset.
module cache_fill_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: issues the block's word reads as the arbiter grants,
// streams returns into the data array and writes the tag with the last word.
module cache_fill_fsm #(
  parameter int AWIDTH      = 16,
  parameter int BLOCK_WORDS = wisc_cache_pkg::BLOCK_WORDS,
  parameter int MEM_LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst,
  cache_fill_if.master  bus
);
  import wisc_cache_pkg::*;

  localparam int WIDX_W = $clog2(BLOCK_WORDS);
  localparam int ICNT_W = WIDX_W + 1;
  localparam int OFF_W  = $clog2(2 * BLOCK_WORDS);
  localparam logic [AWIDTH-1:0] BASE_MASK = ~AWIDTH'((1 << OFF_W) - 1);

  // Returns are counted rather than timed, so latency only needs to be sane.
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
  end

  fill_state_e       state_q, state_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [ICNT_W-1:0] issue_cnt;
  logic [WIDX_W-1:0] recv_cnt;
  logic              cnt_clr, issue_en, recv_en;

  cache_fill_cnt #(.W(ICNT_W)) u_issue_cnt (
    .clk(clk), .rst_n(rst), .clr(cnt_clr), .en(issue_en), .cnt(issue_cnt)
  );

  cache_fill_cnt #(.W(WIDX_W)) u_recv_cnt (
    .clk(clk), .rst_n(rst), .clr(cnt_clr), .en(recv_en), .cnt(recv_cnt)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end

  always_comb begin
    state_d              = state_q;
    base_d               = base_q;
    cnt_clr              = 1'b0;
    issue_en             = 1'b0;
    recv_en              = 1'b0;
    bus.mem_enable       = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.word_offset      = '0;
    bus.write_tag_array  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          state_d = FILL;
          base_d  = bus.miss_address & BASE_MASK;
          cnt_clr = 1'b1;
        end
      end
      FILL: begin
        // Address stays presented while ungranted so issue resumes in place.
        if (issue_cnt < ICNT_W'(BLOCK_WORDS)) begin
          bus.memory_address = base_q + AWIDTH'({issue_cnt, 1'b0});
          bus.mem_enable     = bus.mem_grant;
          issue_en           = bus.mem_grant;
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.word_offset      = recv_cnt;
          recv_en              = 1'b1;
          if (recv_cnt == WIDX_W'(BLOCK_WORDS - 1)) begin
            bus.write_tag_array = 1'b1;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fsm_busy   = (state_q == FILL);
  assign bus.block_base = base_q;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed 4-cycle memory return model.
module tb_cache_fill_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic       tb_mdv;
  logic [3:0] mem_pipe;
  int         tests = 0;
  int         fails = 0;

  cache_fill_if #(.AWIDTH(16), .BLOCK_WORDS(8)) bus ();

  cache_fill_fsm #(.AWIDTH(16), .BLOCK_WORDS(8), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Each granted request returns its word four cycles after issue.
  always @(posedge clk or negedge rst)
    if (!rst) mem_pipe <= 4'b0;
    else      mem_pipe <= {mem_pipe[2:0], bus.mem_enable};

  assign bus.memory_data_valid = mem_pipe[3] | tb_mdv;

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (bus.fsm_busy !== 1'b0) begin fails++; $display("FAIL reset busy got %0b exp 0", bus.fsm_busy); end
    tests++; if (bus.mem_enable !== 1'b0) begin fails++; $display("FAIL reset mem_enable got %0b exp 0", bus.mem_enable); end
    tests++; if (bus.write_data_array !== 1'b0) begin fails++; $display("FAIL reset wda got %0b exp 0", bus.write_data_array); end
    tests++; if (bus.write_tag_array !== 1'b0) begin fails++; $display("FAIL reset wtag got %0b exp 0", bus.write_tag_array); end
    tests++; if (bus.block_base !== 16'h0000) begin fails++; $display("FAIL reset block_base got %h exp 0000", bus.block_base); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic_fill();
    logic       e_busy, e_en, e_wda, e_tag;
    logic [15:0] e_addr;
    logic [2:0] e_off;
    bus.miss_address = 16'h1236;
    bus.mem_grant    = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      bus.miss_detected = (c == 0);
      @(negedge clk);
      e_busy = (c >= 1 && c <= 12);
      e_en   = (c >= 1 && c <= 8);
      e_addr = 16'h1230 + 16'(2 * (c - 1));
      e_wda  = (c >= 5 && c <= 12);
      e_off  = 3'(c - 5);
      e_tag  = (c == 12);
      tests++; if (bus.fsm_busy !== e_busy) begin fails++; $display("FAIL basic busy c=%0d got %0b exp %0b", c, bus.fsm_busy, e_busy); end
      tests++; if (bus.mem_enable !== e_en) begin fails++; $display("FAIL basic mem_enable c=%0d got %0b exp %0b", c, bus.mem_enable, e_en); end
      if (e_en) begin
        tests++; if (bus.memory_address !== e_addr) begin fails++; $display("FAIL basic addr c=%0d got %h exp %h", c, bus.memory_address, e_addr); end
      end
      tests++; if (bus.write_data_array !== e_wda) begin fails++; $display("FAIL basic wda c=%0d got %0b exp %0b", c, bus.write_data_array, e_wda); end
      if (e_wda) begin
        tests++; if (bus.word_offset !== e_off) begin fails++; $display("FAIL basic offset c=%0d got %0d exp %0d", c, bus.word_offset, e_off); end
      end
      tests++; if (bus.write_tag_array !== e_tag) begin fails++; $display("FAIL basic wtag c=%0d got %0b exp %0b", c, bus.write_tag_array, e_tag); end
      if (c == 1) begin
        tests++; if (bus.block_base !== 16'h1230) begin fails++; $display("FAIL basic block_base got %h exp 1230", bus.block_base); end
      end
      next_cyc();
    end
    bus.mem_grant = 1'b0;
  endtask

  task automatic test_grant_stall();
    logic       e_busy, e_en, e_wda, e_tag;
    logic [15:0] e_addr;
    logic [2:0] e_off;
    bus.miss_address = 16'h1236;
    for (int c = 0; c <= 17; c++) begin
      bus.miss_detected = (c == 0);
      bus.mem_grant     = !(c >= 2 && c <= 4);
      @(negedge clk);
      e_busy = (c >= 1 && c <= 15);
      e_en   = (c == 1) || (c >= 5 && c <= 11);
      e_addr = (c == 1) ? 16'h1230 : 16'h1232 + 16'(2 * (c - 5));
      e_wda  = (c == 5) || (c >= 9 && c <= 15);
      e_off  = (c == 5) ? 3'd0 : 3'(c - 8);
      e_tag  = (c == 15);
      tests++; if (bus.fsm_busy !== e_busy) begin fails++; $display("FAIL stall busy c=%0d got %0b exp %0b", c, bus.fsm_busy, e_busy); end
      tests++; if (bus.mem_enable !== e_en) begin fails++; $display("FAIL stall mem_enable c=%0d got %0b exp %0b", c, bus.mem_enable, e_en); end
      if (e_en) begin
        tests++; if (bus.memory_address !== e_addr) begin fails++; $display("FAIL stall addr c=%0d got %h exp %h", c, bus.memory_address, e_addr); end
      end
      if (c >= 2 && c <= 4) begin
        tests++; if (bus.memory_address !== 16'h1232) begin fails++; $display("FAIL stall hold addr c=%0d got %h exp 1232", c, bus.memory_address); end
      end
      tests++; if (bus.write_data_array !== e_wda) begin fails++; $display("FAIL stall wda c=%0d got %0b exp %0b", c, bus.write_data_array, e_wda); end
      if (e_wda) begin
        tests++; if (bus.word_offset !== e_off) begin fails++; $display("FAIL stall offset c=%0d got %0d exp %0d", c, bus.word_offset, e_off); end
      end
      tests++; if (bus.write_tag_array !== e_tag) begin fails++; $display("FAIL stall wtag c=%0d got %0b exp %0b", c, bus.write_tag_array, e_tag); end
      next_cyc();
    end
    bus.mem_grant = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    bus.miss_address = 16'h1234;
    bus.mem_grant    = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      bus.miss_detected = (c == 0);
      next_cyc();
    end
    rst = 1'b0;
    #1;
    tests++; if (bus.fsm_busy !== 1'b0) begin fails++; $display("FAIL rstmid busy got %0b exp 0", bus.fsm_busy); end
    tests++; if (bus.mem_enable !== 1'b0) begin fails++; $display("FAIL rstmid mem_enable got %0b exp 0", bus.mem_enable); end
    tests++; if (bus.write_data_array !== 1'b0) begin fails++; $display("FAIL rstmid wda got %0b exp 0", bus.write_data_array); end
    tests++; if (bus.block_base !== 16'h0000) begin fails++; $display("FAIL rstmid block_base got %h exp 0000", bus.block_base); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++; if (bus.write_tag_array !== 1'b0) begin fails++; $display("FAIL rstmid wtag in reset got %0b exp 0", bus.write_tag_array); end
    end
    next_cyc();
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests++; if (bus.fsm_busy !== 1'b0) begin fails++; $display("FAIL rstmid idle busy c=%0d got %0b exp 0", c, bus.fsm_busy); end
      tests++; if (bus.write_tag_array !== 1'b0) begin fails++; $display("FAIL rstmid idle wtag c=%0d got %0b exp 0", c, bus.write_tag_array); end
      next_cyc();
    end
    bus.mem_grant = 1'b0;
  endtask

  task automatic test_spurious();
    int n_wda = 0;
    int n_tag = 0;
    tb_mdv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (bus.write_data_array !== 1'b0) begin fails++; $display("FAIL spur idle wda c=%0d got %0b exp 0", c, bus.write_data_array); end
      tests++; if (bus.write_tag_array !== 1'b0) begin fails++; $display("FAIL spur idle wtag c=%0d got %0b exp 0", c, bus.write_tag_array); end
      tests++; if (bus.fsm_busy !== 1'b0) begin fails++; $display("FAIL spur idle busy c=%0d got %0b exp 0", c, bus.fsm_busy); end
      next_cyc();
    end
    tb_mdv = 1'b0;
    bus.miss_address = 16'h2000;
    bus.mem_grant    = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      bus.miss_detected = (c <= 12);
      @(negedge clk);
      if (bus.write_data_array === 1'b1) n_wda++;
      if (bus.write_tag_array === 1'b1) n_tag++;
      if (c >= 13) begin
        tests++; if (bus.fsm_busy !== 1'b0) begin fails++; $display("FAIL spur held miss busy c=%0d got %0b exp 0", c, bus.fsm_busy); end
      end
      next_cyc();
    end
    tests++; if (n_tag != 1) begin fails++; $display("FAIL spur tag writes got %0d exp 1", n_tag); end
    tests++; if (n_wda != 8) begin fails++; $display("FAIL spur data writes got %0d exp 8", n_wda); end
    bus.mem_grant = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] last_addr = 16'h0;
    int n_iss = 0;
    int n_bad = 0;
    bus.miss_address = 16'hFFFA;
    bus.mem_grant    = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      bus.miss_detected = (c == 0);
      @(negedge clk);
      if (c == 1) begin
        tests++; if (bus.block_base !== 16'hFFF0) begin fails++; $display("FAIL wrap block_base got %h exp fff0", bus.block_base); end
      end
      if (bus.mem_enable === 1'b1) begin
        n_iss++;
        last_addr = bus.memory_address;
        if (bus.memory_address < 16'hFFF0) n_bad++;
      end
      if (c == 13) begin
        tests++; if (bus.fsm_busy !== 1'b0) begin fails++; $display("FAIL wrap busy at end got %0b exp 0", bus.fsm_busy); end
      end
      next_cyc();
    end
    tests++; if (last_addr !== 16'hFFFE) begin fails++; $display("FAIL wrap last addr got %h exp fffe", last_addr); end
    tests++; if (n_bad != 0) begin fails++; $display("FAIL wrap addrs outside block got %0d exp 0", n_bad); end
    tests++; if (n_iss != 8) begin fails++; $display("FAIL wrap issues got %0d exp 8", n_iss); end
    bus.mem_grant = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n_tag = 0;
    int tag_c = -1;
    bit done  = 1'b0;
    bus.mem_grant = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      bus.miss_detected = (c == 0) || (c >= 11 && c <= 13);
      bus.miss_address  = (c == 0) ? 16'h1236 : 16'h0040;
      @(negedge clk);
      if (c == 12) begin
        tests++; if (bus.write_tag_array !== 1'b1) begin fails++; $display("FAIL b2b first wtag got %0b exp 1", bus.write_tag_array); end
      end
      if (c == 13) begin
        tests++; if (bus.fsm_busy !== 1'b0) begin fails++; $display("FAIL b2b idle gap busy got %0b exp 0", bus.fsm_busy); end
      end
      if (c == 14) begin
        tests++; if (bus.fsm_busy !== 1'b1) begin fails++; $display("FAIL b2b second busy got %0b exp 1", bus.fsm_busy); end
        tests++; if (bus.block_base !== 16'h0040) begin fails++; $display("FAIL b2b block_base got %h exp 0040", bus.block_base); end
        tests++; if (bus.memory_address !== 16'h0040) begin fails++; $display("FAIL b2b first addr got %h exp 0040", bus.memory_address); end
        tests++; if (bus.mem_enable !== 1'b1) begin fails++; $display("FAIL b2b mem_enable got %0b exp 1", bus.mem_enable); end
      end
      next_cyc();
    end
    bus.miss_detected = 1'b0;
    for (int c = 15; c < 60 && !done; c++) begin
      @(negedge clk);
      if (bus.write_tag_array === 1'b1) begin n_tag++; tag_c = c; end
      if (bus.fsm_busy === 1'b0) done = 1'b1;
      next_cyc();
    end
    tests++; if (!done) begin fails++; $display("FAIL b2b timeout busy got 1 exp 0 within 60 cycles"); end
    tests++; if (n_tag != 1) begin fails++; $display("FAIL b2b second tag writes got %0d exp 1", n_tag); end
    tests++; if (tag_c != 25) begin fails++; $display("FAIL b2b second tag cycle got %0d exp 25", tag_c); end
    bus.mem_grant = 1'b0;
  endtask

  initial begin
    rst                = 1'b0;
    tb_mdv             = 1'b0;
    bus.miss_detected  = 1'b0;
    bus.miss_address   = 16'h0;
    bus.mem_grant      = 1'b0;
    test_reset();
    next_cyc();
    test_basic_fill();
    test_grant_stall();
    test_reset_mid_fill();
    test_spurious();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
